// File: rtl/vga_sync_generator.sv
// vga_sync_generator
// Raster timing generator: free-running horizontal/vertical counters advanced by a
// pixel-rate enable, decoded into registered sync pulses, an active-video qualifier,
// pixel coordinates and a one-clock frame-start strobe.
module vga_sync_generator #(
  parameter int WIDTH       = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int HEIGHT      = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   tick_in,
  output logic [WIDTH_BITS-1:0]  pixel_x_out,
  output logic [HEIGHT_BITS-1:0] pixel_y_out,
  output logic                   video_on_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   frame_start_out
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Last count of each counter; reset parks here so the first tick lands on (0,0).
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Decode boundaries are one bit wider than the counters so that a range end
  // equal to the total (zero back porch) cannot alias to zero.
  localparam logic [HW:0] H_VIS_END  = (HW+1)'(WIDTH);
  localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(WIDTH + H_FRONT);
  localparam logic [HW:0] H_SYNC_END = (HW+1)'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [VW:0] V_VIS_END  = (VW+1)'(HEIGHT);
  localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(HEIGHT + V_FRONT);
  localparam logic [VW:0] V_SYNC_END = (VW+1)'(HEIGHT + V_FRONT + V_SYNC);

  // Coordinate outputs must be able to represent every visible column and line.
  generate
    if (WIDTH > 2**WIDTH_BITS) begin : g_width_bits_check
      $error("vga_sync_generator: WIDTH does not fit in WIDTH_BITS");
    end
    if (HEIGHT > 2**HEIGHT_BITS) begin : g_height_bits_check
      $error("vga_sync_generator: HEIGHT does not fit in HEIGHT_BITS");
    end
  endgenerate

  logic [HW-1:0]          h_count_reg, h_count_next;
  logic [VW-1:0]          v_count_reg, v_count_next;
  logic [HW:0]            h_ext;
  logic [VW:0]            v_ext;
  logic                   h_visible, v_visible;
  logic [WIDTH_BITS-1:0]  pixel_x_next;
  logic [HEIGHT_BITS-1:0] pixel_y_next;
  logic                   video_on_next;
  logic                   h_sync_next;
  logic                   v_sync_next;
  logic                   frame_start_next;

  // Counter advance: h steps every tick, v steps only on the h wrap.
  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (tick_in) begin
      if (h_count_reg == H_LAST) begin
        h_count_next = '0;
        if (v_count_reg == V_LAST) begin
          v_count_next = '0;
        end else begin
          v_count_next = v_count_reg + 1'b1;
        end
      end else begin
        h_count_next = h_count_reg + 1'b1;
      end
    end
  end

  // Output decode from the position being entered, so registered outputs line up
  // with the counters on the same edge.
  always_comb begin
    h_ext            = {1'b0, h_count_next};
    v_ext            = {1'b0, v_count_next};
    h_visible        = (h_ext < H_VIS_END);
    v_visible        = (v_ext < V_VIS_END);
    video_on_next    = h_visible && v_visible;
    pixel_x_next     = h_visible ? WIDTH_BITS'(h_count_next) : '0;
    pixel_y_next     = v_visible ? HEIGHT_BITS'(v_count_next) : '0;
    h_sync_next      = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    v_sync_next      = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_start_next = tick_in && (h_count_next == '0) && (v_count_next == '0);
  end

  // State and output registers; everything but the frame strobe holds on non-tick clocks.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      h_count_reg     <= H_LAST;
      v_count_reg     <= V_LAST;
      pixel_x_out     <= '0;
      pixel_y_out     <= '0;
      video_on_out    <= 1'b0;
      h_sync_out      <= ~SYNC_ACTIVE;
      v_sync_out      <= ~SYNC_ACTIVE;
      frame_start_out <= 1'b0;
    end else begin
      frame_start_out <= frame_start_next;
      if (tick_in) begin
        h_count_reg  <= h_count_next;
        v_count_reg  <= v_count_next;
        pixel_x_out  <= pixel_x_next;
        pixel_y_out  <= pixel_y_next;
        video_on_out <= video_on_next;
        h_sync_out   <= h_sync_next;
        v_sync_out   <= v_sync_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator
// Bench for vga_sync_generator on a small raster (25 x 19 positions) so that whole
// frames fit in a short run. Expected outputs come from a position model that maps
// the number of enabled ticks since reset straight to (h,v) and decodes the rules.
module tb_vga_sync_generator;

  localparam int W     = 16;
  localparam int HF    = 2;
  localparam int HS    = 3;
  localparam int HBK   = 4;
  localparam int H     = 12;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int WB    = 4;
  localparam int HBITS = 4;
  localparam bit SA    = 1'b0;
  localparam int HT    = W + HF + HS + HBK;
  localparam int VT    = H + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int OW    = WB + HBITS + 4;

  typedef logic [OW-1:0] obs_t;

  logic             clock_in = 1'b0;
  logic             reset_in = 1'b0;
  logic             tick_in  = 1'b0;
  logic [WB-1:0]    pixel_x_out;
  logic [HBITS-1:0] pixel_y_out;
  logic             video_on_out;
  logic             h_sync_out;
  logic             v_sync_out;
  logic             frame_start_out;
  obs_t             observed;

  int n_tests = 0;
  int n_fail  = 0;
  int ticks   = 0;   // enabled ticks counted since the last reset
  bit fs_exp  = 1'b0;

  vga_sync_generator #(
    .WIDTH(W), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
    .HEIGHT(H), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .WIDTH_BITS(WB), .HEIGHT_BITS(HBITS), .SYNC_ACTIVE(SA)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .tick_in(tick_in),
    .pixel_x_out(pixel_x_out),
    .pixel_y_out(pixel_y_out),
    .video_on_out(video_on_out),
    .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out),
    .frame_start_out(frame_start_out)
  );

  assign observed = {pixel_x_out, pixel_y_out, video_on_out, h_sync_out, v_sync_out, frame_start_out};

  always #5 clock_in = ~clock_in;

  // Expected outputs after k enabled ticks since reset; tick k lands on linear position k-1.
  function automatic obs_t model(input int k, input bit fs);
    int p, h, v;
    logic [WB-1:0]    x;
    logic [HBITS-1:0] y;
    bit von, hsy, vsy;
    if (k == 0) return {WB'(0), HBITS'(0), 1'b0, ~SA, ~SA, 1'b0};
    p   = (k - 1) % FRAME;
    h   = p % HT;
    v   = p / HT;
    von = (h < W) && (v < H);
    x   = (h < W) ? WB'(h) : '0;
    y   = (v < H) ? HBITS'(v) : '0;
    hsy = (h >= W + HF && h < W + HF + HS) ? SA : ~SA;
    vsy = (v >= H + VF && v < H + VF + VS) ? SA : ~SA;
    return {x, y, von, hsy, vsy, fs};
  endfunction

  // One clock with the given tick level; updates the tick count, sampled 1ns after the edge.
  task automatic clk_step(input bit t);
    tick_in = t;
    @(posedge clock_in);
    if (reset_in) begin
      ticks  = 0;
      fs_exp = 1'b0;
    end else if (t) begin
      ticks  = ticks + 1;
      fs_exp = ((ticks - 1) % FRAME == 0);
    end else begin
      fs_exp = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    #2;
    reset_in = 1'b1;
    ticks    = 0;
    #1;
    n_tests++;
    if (observed !== model(0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", observed, model(0, 1'b0));
    end
    for (int i = 0; i < 5; i++) begin
      clk_step(1'b1);
      n_tests++;
      if (observed !== model(0, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, observed, model(0, 1'b0));
      end
    end
    $display("[TB] reset held 5 clocks");
  endtask

  task automatic test_first_ticks();
    reset_in = 1'b0;
    clk_step(1'b1);
    n_tests++;
    if (observed !== model(ticks, fs_exp) || frame_start_out !== 1'b1 || video_on_out !== 1'b1) begin
      n_fail++;
      $display("FAIL first_tick: got %h expected %h", observed, model(ticks, fs_exp));
    end
    clk_step(1'b1);
    n_tests++;
    if (pixel_x_out !== WB'(1) || frame_start_out !== 1'b0 || observed !== model(ticks, fs_exp)) begin
      n_fail++;
      $display("FAIL second_tick: got %h expected %h", observed, model(ticks, fs_exp));
    end
    $display("[TB] first ticks checked");
  endtask

  task automatic test_line();
    int guard = 0;
    int von_cnt = 0, hs_low = 0, hs_first = -1;
    while (frame_start_out !== 1'b1 && guard < 2 * FRAME) begin
      clk_step(1'b1);
      guard++;
    end
    n_tests++;
    if (frame_start_out !== 1'b1) begin
      n_fail++;
      $display("FAIL line_sync_timeout: got %0d expected <%0d clocks", guard, 2 * FRAME);
    end
    for (int i = 0; i < HT; i++) begin
      if (video_on_out === 1'b1) von_cnt++;
      if (h_sync_out === SA) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      clk_step(1'b1);
      n_tests++;
      if (observed !== model(ticks, fs_exp)) begin
        n_fail++;
        $display("FAIL line_model[%0d]: got %h expected %h", i, observed, model(ticks, fs_exp));
      end
    end
    n_tests++;
    if (von_cnt != W || hs_low != HS || hs_first != W + HF) begin
      n_fail++;
      $display("FAIL line_counts: got von=%0d hs=%0d first=%0d expected von=%0d hs=%0d first=%0d",
               von_cnt, hs_low, hs_first, W, HS, W + HF);
    end
    n_tests++;
    if (pixel_y_out !== HBITS'(1) || pixel_x_out !== WB'(0)) begin
      n_fail++;
      $display("FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", pixel_x_out, pixel_y_out);
    end
    $display("[TB] line von=%0d hsync_low=%0d first=%0d", von_cnt, hs_low, hs_first);
  endtask

  task automatic test_frame();
    int guard = 0;
    int vs_low = 0, vs_first = -1, fs_cnt = 0, y_max = 0, y_blank_bad = 0;
    while (frame_start_out !== 1'b1 && guard < 2 * FRAME) begin
      clk_step(1'b1);
      guard++;
    end
    n_tests++;
    if (frame_start_out !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_sync_timeout: got %0d expected <%0d clocks", guard, 2 * FRAME);
    end
    for (int i = 0; i < FRAME; i++) begin
      if (v_sync_out === SA) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
      end
      if (i > 0 && frame_start_out === 1'b1) fs_cnt++;
      if (int'(pixel_y_out) > y_max) y_max = int'(pixel_y_out);
      if (i / HT >= H && pixel_y_out !== '0) y_blank_bad++;
      clk_step(1'b1);
      n_tests++;
      if (observed !== model(ticks, fs_exp)) begin
        n_fail++;
        $display("FAIL frame_model[%0d]: got %h expected %h", i, observed, model(ticks, fs_exp));
      end
    end
    n_tests++;
    if (frame_start_out !== 1'b1 || fs_cnt != 0) begin
      n_fail++;
      $display("FAIL frame_period: got fs=%b extra=%0d expected fs=1 extra=0", frame_start_out, fs_cnt);
    end
    n_tests++;
    if (vs_low != VS * HT || vs_first != (H + VF) * HT) begin
      n_fail++;
      $display("FAIL frame_vsync: got low=%0d first=%0d expected low=%0d first=%0d",
               vs_low, vs_first, VS * HT, (H + VF) * HT);
    end
    n_tests++;
    if (y_max != H - 1 || y_blank_bad != 0) begin
      n_fail++;
      $display("FAIL frame_y: got max=%0d blank_nonzero=%0d expected max=%0d blank_nonzero=0",
               y_max, y_blank_bad, H - 1);
    end
    $display("[TB] frame vsync_low=%0d first=%0d ymax=%0d", vs_low, vs_first, y_max);
  endtask

  task automatic test_tick_toggle();
    int period = 0, fs_cnt = 0;
    bit t = 1'b0;
    while (frame_start_out !== 1'b1 && period < 2 * FRAME) begin
      clk_step(1'b1);
      period++;
    end
    period = 0;
    do begin
      clk_step(t);
      t = ~t;
      period++;
      if (frame_start_out === 1'b1) fs_cnt++;
      n_tests++;
      if (observed !== model(ticks, fs_exp)) begin
        n_fail++;
        $display("FAIL toggle_model[%0d]: got %h expected %h", period, observed, model(ticks, fs_exp));
      end
    end while (frame_start_out !== 1'b1 && period < 3 * FRAME);
    n_tests++;
    if (period != 2 * FRAME || fs_cnt != 1) begin
      n_fail++;
      $display("FAIL toggle_period: got period=%0d pulses=%0d expected period=%0d pulses=1",
               period, fs_cnt, 2 * FRAME);
    end
    $display("[TB] toggle period=%0d", period);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3 * FRAME; i++) begin
      clk_step(($urandom % 4) != 0);
      n_tests++;
      if (observed !== model(ticks, fs_exp)) begin
        n_fail++;
        $display("FAIL random_model[%0d]: got %h expected %h", i, observed, model(ticks, fs_exp));
      end
    end
    $display("[TB] random tick run ticks=%0d", ticks);
  endtask

  task automatic test_midframe_reset();
    int period = 0;
    // Fresh start, then walk to (10,5).
    reset_in = 1'b1;
    ticks    = 0;
    clk_step(1'b0);
    reset_in = 1'b0;
    for (int i = 0; i < 5 * HT + 10 + 1; i++) clk_step(1'b1);
    n_tests++;
    if (pixel_x_out !== WB'(10) || pixel_y_out !== HBITS'(5) || observed !== model(ticks, fs_exp)) begin
      n_fail++;
      $display("FAIL mid_position: got x=%0d y=%0d expected x=10 y=5", pixel_x_out, pixel_y_out);
    end
    #3;
    reset_in = 1'b1;
    ticks    = 0;
    #1;
    n_tests++;
    if (observed !== model(0, 1'b0)) begin
      n_fail++;
      $display("FAIL mid_async: got %h expected %h", observed, model(0, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      clk_step(1'b1);
      n_tests++;
      if (observed !== model(0, 1'b0)) begin
        n_fail++;
        $display("FAIL mid_hold[%0d]: got %h expected %h", i, observed, model(0, 1'b0));
      end
    end
    reset_in = 1'b0;
    clk_step(1'b1);
    n_tests++;
    if (frame_start_out !== 1'b1 || observed !== model(ticks, fs_exp)) begin
      n_fail++;
      $display("FAIL mid_restart: got %h expected %h", observed, model(ticks, fs_exp));
    end
    do begin
      clk_step(1'b1);
      period++;
    end while (frame_start_out !== 1'b1 && period < 2 * FRAME);
    n_tests++;
    if (period != FRAME) begin
      n_fail++;
      $display("FAIL mid_frame_period: got %0d expected %0d", period, FRAME);
    end
    $display("[TB] mid-frame reset, next frame after %0d clocks", period);
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_line();
    test_frame();
    test_tick_toggle();
    test_random();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
